// File: rtl/anabellek_pkg.sv
// Shared types and widths for the memory responder slice.
// State encoding and the default RAM window base live here.
package anabellek_pkg;

   typedef enum logic [1:0] {
      BOSTA = 2'd0,
      BEKLE = 2'd1,
      YANIT = 2'd2
   } durum_t;

   localparam int VERI_BIT  = 32;
   localparam int ADRES_BIT = 32;

   // Same value as the core's reset PC.
   localparam logic [ADRES_BIT-1:0] TABAN_VARSAYILAN = 32'h8000_0000;

endpackage

// File: rtl/anabellek_yanitlayici_dizi.sv
// Single-port synchronous RAM with registered read and no reset.
// Read data register only updates when a read is requested.
module bellek_dizisi
   import anabellek_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int IW          = $clog2(DEPTH_WORDS)
) (
   input  logic                clk,
   input  logic                yaz,
   input  logic                oku,
   input  logic [IW-1:0]       indis,
   input  logic [VERI_BIT-1:0] yaz_veri,
   output logic [VERI_BIT-1:0] oku_veri
);

   logic [VERI_BIT-1:0] dizi [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (yaz) dizi[indis] <= yaz_veri;
      if (oku) oku_veri <= dizi[indis];
   end

endmodule

// File: rtl/anabellek_yanitlayici.sv
// Memory responder: one request at a time, window decode,
// programmable wait states, one-cycle ready pulse.
module anabellek_yanitlayici
   import anabellek_pkg::*;
#(
   parameter logic [ADRES_BIT-1:0] BASE_ADDR   = TABAN_VARSAYILAN,
   parameter int                   DEPTH_WORDS = 1024,
   parameter int                   WAIT_STATES = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 bellek_istek,
   input  logic [ADRES_BIT-1:0] bellek_adres,
   input  logic                 bellek_yaz,
   input  logic [VERI_BIT-1:0]  bellek_yaz_veri,
   output logic [VERI_BIT-1:0]  bellek_oku_veri,
   output logic                 bellek_hazir,
   output logic                 bellek_hata,
   output logic [15:0]          okuma_sayisi,
   output logic [15:0]          yazma_sayisi
);

   localparam int IW = $clog2(DEPTH_WORDS);
   localparam logic [ADRES_BIT:0] SINIR = 33'(DEPTH_WORDS) << 2;
   localparam logic [3:0] BEKLEME = 4'(WAIT_STATES);

   durum_t               durum;
   logic [3:0]           sayac;
   logic [ADRES_BIT-1:0] adres_r;
   logic                 yaz_r;
   logic [VERI_BIT-1:0]  veri_r;
   logic                 hata_r;
   logic                 sifir;
   logic                 hazir_r;
   logic [15:0]          okuma_r;
   logic [15:0]          yazma_r;

   logic                 kabul;
   logic                 islem;
   logic                 yeni_hata;
   logic [ADRES_BIT-1:0] a_adres;
   logic                 a_yaz;
   logic [VERI_BIT-1:0]  a_veri;
   logic                 a_hata;
   logic [IW-1:0]        indis;
   logic                 ram_yaz;
   logic                 ram_oku;
   logic [VERI_BIT-1:0]  ram_q;

   assign kabul = (durum == BOSTA) && bellek_istek;

   // No wrap: addresses below BASE are rejected before the range test.
   assign yeni_hata = (bellek_adres[1:0] != 2'b00)
                    | (bellek_adres < BASE_ADDR)
                    | ({1'b0, bellek_adres - BASE_ADDR} >= SINIR);

   // With zero wait states the commit uses the live request.
   always_comb begin
      a_adres = adres_r;
      a_yaz   = yaz_r;
      a_veri  = veri_r;
      a_hata  = hata_r;
      if (durum == BOSTA) begin
         a_adres = bellek_adres;
         a_yaz   = bellek_yaz;
         a_veri  = bellek_yaz_veri;
         a_hata  = yeni_hata;
      end
   end

   assign islem = !rst
                && ((kabul && BEKLEME == 4'd0)
                 || (durum == BEKLE && sayac == 4'd1));

   assign indis   = IW'((a_adres - BASE_ADDR) >> 2);
   assign ram_yaz = islem & a_yaz & ~a_hata;
   assign ram_oku = islem & ~a_yaz & ~a_hata;

   bellek_dizisi #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IW          (IW)
   ) u_dizi (
      .clk      (clk),
      .yaz      (ram_yaz),
      .oku      (ram_oku),
      .indis    (indis),
      .yaz_veri (a_veri),
      .oku_veri (ram_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         durum   <= BOSTA;
         sayac   <= 4'd0;
         adres_r <= '0;
         yaz_r   <= 1'b0;
         veri_r  <= '0;
         hata_r  <= 1'b0;
         sifir   <= 1'b1;
         hazir_r <= 1'b0;
         okuma_r <= 16'd0;
         yazma_r <= 16'd0;
      end else begin
         hazir_r <= islem;
         if (islem) begin
            if (a_hata) sifir <= 1'b1;
            else if (!a_yaz) sifir <= 1'b0;
            if (!a_hata && !a_yaz && okuma_r != 16'hFFFF)
               okuma_r <= okuma_r + 16'd1;
            if (!a_hata && a_yaz && yazma_r != 16'hFFFF)
               yazma_r <= yazma_r + 16'd1;
         end
         unique case (durum)
            BOSTA: begin
               if (bellek_istek) begin
                  adres_r <= bellek_adres;
                  yaz_r   <= bellek_yaz;
                  veri_r  <= bellek_yaz_veri;
                  hata_r  <= yeni_hata;
                  sayac   <= BEKLEME;
                  durum   <= (BEKLEME == 4'd0) ? YANIT : BEKLE;
               end
            end
            BEKLE: begin
               sayac <= sayac - 4'd1;
               if (sayac == 4'd1) durum <= YANIT;
            end
            YANIT:   durum <= BOSTA;
            default: durum <= BOSTA;
         endcase
      end
   end

   // A zeroed result is shown until the next successful read.
   assign bellek_oku_veri = sifir ? '0 : ram_q;
   assign bellek_hazir    = hazir_r;
   assign bellek_hata     = hazir_r & hata_r;
   assign okuma_sayisi    = okuma_r;
   assign yazma_sayisi    = yazma_r;

endmodule
